// File: rtl/des_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : des_round_engine
//  Purpose  : Iterative DES datapath. IP, then 16 Feistel rounds at one round
//             per subkey handshake, then FP.
//  Revision : 1.0 - initial release
// ============================================================================
module des_round_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] dataIn,
    output logic [5:0]  keyid,
    output logic        subkey_req,
    input  logic        subkey_vld,
    input  logic [1:48] branchkey,
    output logic        busy,
    output logic        done,
    output logic [1:64] dataOut
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is stored row-major: entry index = row*16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    logic [2:0]  state_q, state_d;
    logic [1:32] l_q, l_d, r_q, r_d;
    logic [4:0]  rnd_q, rnd_d;
    logic        dec_q, dec_d;
    logic [5:0]  keyid_q, keyid_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:64] dout_q, dout_d;

    logic [1:64] w_ip;
    logic [1:48] w_exp, w_sin;
    logic [1:32] w_sout, w_f, w_rnew;
    logic [1:64] w_preout, w_fp;

    for (genvar g = 0; g < 64; g++) begin : g_ip
        assign w_ip[g+1] = dataIn[IP_TBL[g]];
    end

    for (genvar g = 0; g < 48; g++) begin : g_exp
        assign w_exp[g+1] = r_q[E_TBL[g]];
    end

    assign w_sin = w_exp ^ branchkey;

    // Row comes from the outer bits of each 6-bit group, column from the inner four.
    for (genvar b = 0; b < 8; b++) begin : g_sbox
        logic [5:0] w_six;
        assign w_six = w_sin[6*b+1 +: 6];
        assign w_sout[4*b+1 +: 4] = SBOX[b][{w_six[5], w_six[0], w_six[4:1]}];
    end

    for (genvar g = 0; g < 32; g++) begin : g_perm
        assign w_f[g+1] = w_sout[P_TBL[g]];
    end

    assign w_rnew   = l_q ^ w_f;
    // Last round output is presented as {R16, L16}, undoing the final swap.
    assign w_preout = {w_rnew, r_q};

    for (genvar g = 0; g < 64; g++) begin : g_fp
        assign w_fp[g+1] = w_preout[FP_TBL[g]];
    end

    function automatic logic [5:0] key_index(input logic dec, input logic [4:0] rnd);
        key_index = dec ? (6'd17 - {1'b0, rnd}) : {1'b0, rnd};
    endfunction

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        keyid_d = keyid_q;
        req_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    dec_d   = decrypt;
                    l_d     = w_ip[1:32];
                    r_d     = w_ip[33:64];
                    rnd_d   = 5'd1;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                keyid_d = key_index(dec_q, rnd_q);
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (subkey_vld) begin
                    l_d = r_q;
                    r_d = w_rnew;
                    if (rnd_q == 5'd16) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dout_d  = w_fp;
                        keyid_d = 6'd0;
                    end else begin
                        state_d = S_REQ;
                        rnd_d   = rnd_q + 5'd1;
                        req_d   = 1'b1;
                        keyid_d = key_index(dec_q, rnd_q + 5'd1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
            keyid_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
            keyid_q <= keyid_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign keyid      = keyid_q;
    assign subkey_req = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dataOut    = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_des_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_round_engine
//  Purpose  : Directed self-checking bench for des_round_engine with a
//             key-schedule subkey provider of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_round_engine;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [1:64] dataIn;
    logic [5:0]  keyid;
    logic        subkey_req;
    logic        subkey_vld = 1'b0;
    logic [1:48] branchkey = '0;
    logic        busy;
    logic        done;
    logic [1:64] dataOut;

    int n_checks = 0;
    int n_fails  = 0;

    logic [1:48] K [1:16];

    int          prov_lat     = 1;
    bit          spur_idle    = 1'b0;
    int          spur_req_kid = 0;
    int          cnt          = 0;
    logic [5:0]  kid          = '0;
    int          nreq         = 0;
    int          nfire        = 0;
    logic [5:0]  req_log      [512];
    logic [5:0]  fire_kid_log [512];
    logic [1:48] fire_key_log [512];

    des_round_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .decrypt    (decrypt),
        .dataIn     (dataIn),
        .keyid      (keyid),
        .subkey_req (subkey_req),
        .subkey_vld (subkey_vld),
        .branchkey  (branchkey),
        .busy       (busy),
        .done       (done),
        .dataOut    (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_keys(input logic [1:64] key);
        logic [1:56] cd;
        logic [1:28] c, d;
        for (int i = 0; i < 56; i++) cd[i+1] = key[PC1[i]];
        c = cd[1:28];
        d = cd[29:56];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) K[r+1][j+1] = cd[PC2[j]];
        end
    endtask

    // Subkey provider: answers each request prov_lat cycles later.
    always @(negedge clk) begin
        subkey_vld = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    subkey_vld = 1'b1;
                    branchkey  = K[kid];
                    fire_kid_log[nfire % 512] = kid;
                    fire_key_log[nfire % 512] = K[kid];
                    nfire = nfire + 1;
                end
            end
            if (subkey_req) begin
                kid = keyid;
                cnt = prov_lat;
                req_log[nreq % 512] = keyid;
                nreq = nreq + 1;
                if (spur_req_kid != 0 && int'(keyid) == spur_req_kid) begin
                    subkey_vld = 1'b1;
                    branchkey  = ~K[kid];
                end
            end
        end
        if (spur_idle) subkey_vld = 1'b1;
    end

    task automatic run_op(input logic dec, input logic [1:64] din, input int lat, input bit inj,
                          output logic [1:64] dout, output int dcyc);
        int cyc;
        bit got;
        bit busy_ok;
        int rbase;
        int seq_err;
        prov_lat = lat;
        @(negedge clk);
        check_eq("pre_start_busy", 64'(busy), 64'd0);
        check_eq("pre_start_done", 64'(done), 64'd0);
        rbase   = nreq;
        start   = 1'b1;
        decrypt = dec;
        dataIn  = din;
        @(negedge clk);
        start   = 1'b0;
        decrypt = ~dec;
        dataIn  = ~din;
        cyc     = 1;
        got     = 1'b0;
        busy_ok = 1'b1;
        dout    = '0;
        dcyc    = 0;
        while (!got && cyc < 400) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got  = 1'b1;
                dout = dataOut;
                dcyc = cyc;
            end else begin
                if (inj && cyc == 10) begin
                    start  = 1'b1;
                    dataIn = '1;
                end else begin
                    start  = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check_eq("done_seen", 64'(got), 64'd1);
        check_eq("busy_window", 64'(busy_ok), 64'd1);
        check_eq("req_count", 64'(nreq - rbase), 64'd16);
        seq_err = 0;
        for (int i = 0; i < 16; i++)
            if (req_log[(rbase + i) % 512] !== 6'(dec ? (16 - i) : (i + 1))) seq_err++;
        check_eq("keyid_seq", 64'(seq_err), 64'd0);
    endtask

    initial begin
        logic [1:64] res;
        int          dc;
        int          fbase;
        bit          saw_done;

        rst_n   = 1'b0;
        start   = 1'b0;
        decrypt = 1'b0;
        dataIn  = '0;
        build_keys(64'h133457799BBCDFF1);
        repeat (3) @(negedge clk);
        check_eq("reset_busy",    64'(busy),       64'd0);
        check_eq("reset_done",    64'(done),       64'd0);
        check_eq("reset_req",     64'(subkey_req), 64'd0);
        check_eq("reset_keyid",   64'(keyid),      64'd0);
        check_eq("reset_dataout", 64'(dataOut),    64'd0);
        rst_n = 1'b1;

        fbase = nfire;
        run_op(1'b0, 64'h0123456789ABCDEF, 1, 1'b0, res, dc);
        check_eq("enc_result",      64'(res), 64'h85E813540F0AB405);
        check_eq("enc_done_cycle",  64'(dc),  64'd34);
        check_eq("first_keyid",     64'(fire_kid_log[fbase % 512]), 64'd1);
        check_eq("first_branchkey", 64'(fire_key_log[fbase % 512]), 64'h1B02EFFC7072);

        run_op(1'b1, 64'h85E813540F0AB405, 1, 1'b0, res, dc);
        check_eq("b2b_dec_result", 64'(res), 64'h0123456789ABCDEF);
        check_eq("b2b_dec_cycle",  64'(dc),  64'd34);

        run_op(1'b0, 64'h0123456789ABCDEF, 4, 1'b0, res, dc);
        check_eq("lat4_result", 64'(res), 64'h85E813540F0AB405);
        check_eq("lat4_cycle",  64'(dc),  64'd82);

        run_op(1'b0, 64'h0123456789ABCDEF, 1, 1'b1, res, dc);
        check_eq("spur_start_result", 64'(res), 64'h85E813540F0AB405);

        spur_idle = 1'b1;
        repeat (2) @(negedge clk);
        spur_idle = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_vld_busy",  64'(busy),       64'd0);
        check_eq("idle_vld_req",   64'(subkey_req), 64'd0);
        check_eq("idle_vld_keyid", 64'(keyid),      64'd0);
        check_eq("idle_vld_held",  64'(dataOut),    64'h85E813540F0AB405);

        spur_req_kid = 3;
        run_op(1'b1, 64'h85E813540F0AB405, 1, 1'b0, res, dc);
        spur_req_kid = 0;
        check_eq("req_vld_result", 64'(res), 64'h0123456789ABCDEF);

        // Abort in the WAIT phase of round 8.
        @(negedge clk);
        start   = 1'b1;
        decrypt = 1'b0;
        dataIn  = 64'h0123456789ABCDEF;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("round8_keyid", 64'(keyid), 64'd8);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy",    64'(busy),       64'd0);
        check_eq("abort_keyid",   64'(keyid),      64'd0);
        check_eq("abort_req",     64'(subkey_req), 64'd0);
        check_eq("abort_dataout", 64'(dataOut),    64'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 64'(saw_done), 64'd0);

        build_keys(64'h0E329232EA6D0D73);
        run_op(1'b0, 64'h8787878787878787, 1, 1'b0, res, dc);
        check_eq("post_abort_enc",   64'(res), 64'h0000000000000000);
        check_eq("post_abort_cycle", 64'(dc),  64'd34);
        run_op(1'b1, 64'h0000000000000000, 2, 1'b0, res, dc);
        check_eq("key2_dec_result", 64'(res), 64'h8787878787878787);
        check_eq("key2_dec_cycle",  64'(dc),  64'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/des_round_engine.md
# des_round_engine

Iterative DES datapath that consumes the 48-bit round subkeys produced by the team's branch key generator. It applies IP, then 16 Feistel rounds at one round per subkey handshake, then FP. It requests subkeys by index through a req/vld handshake, so it tolerates any key-generator latency. It sits directly downstream of the key schedule and directly upstream of the block-level output register.

## Interface
Parameters: none.

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  one-cycle request to process dataIn; sampled only in IDLE
- decrypt  input  1  0 = encrypt (subkeys 1..16), 1 = decrypt (subkeys 16..1); sampled with start
- dataIn  input  [1:64]  plaintext/ciphertext, DES bit numbering (bit 1 = MSB); sampled with start
- keyid  output  [5:0]  subkey index requested, 1..16; 0 when not requesting
- subkey_req  output  1  one-cycle pulse; keyid valid while high
- subkey_vld  input  1  subkey provider strobe; branchkey valid while high
- branchkey  input  [1:48]  subkey Kn for the last requested keyid
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse, dataOut valid
- dataOut  output  [1:64]  result, held until the next done or reset

## Operation
- FSM states:
  - IDLE
    - start=1 → LOAD.
    - Capture mode and IP(dataIn) into L[1:32], R[1:32].
    - Round counter rnd=1.
  - LOAD → REQ, unconditionally.
  - REQ
    - subkey_req=1.
    - keyid = rnd (encrypt) or 17-rnd (decrypt).
    - → WAIT.
  - WAIT
    - Hold keyid at the requested index, subkey_req=0.
    - On subkey_vld=1:
      - L<=R.
      - R<=L ^ P(S(E(R) ^ branchkey)).
      - If rnd==16 → DONE, else rnd++ and → REQ.
    - subkey_vld=0: stay, no timeout.
  - DONE
    - done=1.
    - dataOut was loaded on the entering edge with FP({R16,L16}), i.e. the final swap is undone.
    - → IDLE.
- E, P, IP, FP and S1..S8 follow FIPS 46-3 exactly. The S-boxes are combinational lookup. Row = bits 1,6 of each 6-bit group; column = bits 2..5.
- rnd is a 5-bit counter that never wraps. The 16th accepted subkey ends the operation.
- subkey_vld outside WAIT is ignored, including a vld coinciding with subkey_req in REQ. Providers must answer ≥1 cycle after req.
- A start outside IDLE is ignored; an in-flight operation is not disturbed. decrypt/dataIn changes after acceptance have no effect.
- Reset values:
  - state=IDLE, busy=0, done=0, subkey_req=0, keyid=0, dataOut=0.
  - L=R=0, rnd=0.
- Reset mid-operation aborts immediately. No done is emitted, and dataOut returns to 0.

## Timing
- Edge 0 samples start. LOAD occupies cycle 1.
- Round n: REQ in cycle 2n, WAIT from cycle 2n+1.
- With provider latency d≥1 cycles after req:
  - Each round takes 1+d cycles.
  - done rises in cycle 2+16·(1+d); 34 for d=1.
- busy is high from cycle 1 through the DONE cycle inclusive. It is low in the cycle after done, and a new start may be accepted there.
- keyid is registered. It changes only on entry to REQ and returns to 0 on entry to DONE.
- No combinational path from any input to any output.

## Test plan
- Encrypt, key 133457799BBCDFF1 via a key model, d=1.
  - dataIn=0123456789ABCDEF, decrypt=0 → dataOut=85E813540F0AB405, done in cycle 34.
  - First branchkey observed = 1B02EFFC7072 for keyid=1.
- Decrypt, same key, dataIn=85E813540F0AB405, decrypt=1.
  - keyid sequence 16,15,…,1 → dataOut=0123456789ABCDEF.
- Variable latency: provider answers after 4 cycles.
  - Same vector → same result.
  - done in cycle 2+16·5=82.
  - busy stays high throughout.
- Spurious and overlapping inputs:
  - start pulsed during round 5 with dataIn=FFFF…F → ignored, result unchanged.
  - subkey_vld pulsed in IDLE and in REQ → no state change.
- Reset mid-operation:
  - Assert rst_n=0 during round 8 WAIT → next sample shows busy=0, keyid=0, dataOut=0.
  - No done pulse.
  - A fresh start then completes correctly.
- Back-to-back: start asserted the cycle after done → accepted, second result correct.
